// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, receiver states,
// 50 MHz baud divisors and the 3-tap majority helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned B115200 = 434;
  localparam int unsigned B57600  = 868;
  localparam int unsigned B38400  = 1302;
  localparam int unsigned B19200  = 2604;
  localparam int unsigned B9600   = 5208;
  localparam int unsigned B4800   = 10417;
  localparam int unsigned B2400   = 20833;
  localparam int unsigned B1200   = 41667;
  localparam int unsigned B600    = 83333;
  localparam int unsigned B300    = 166667;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter with mid-bit strobe, bit-end strobe and 3-tap majority voter.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = B115200
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart_i,
  input  logic rx_i,
  output logic sample_o,
  output logic bit_end_o,
  output logic bit_o
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    tap_q, tap_d;

  always_comb begin
    tap_d = tap_q;
    if (restart_i || cnt_q == CW'(CLKS_PER_BIT - 1)) cnt_d = '0;
    else                                             cnt_d = cnt_q + 1'b1;
    if (cnt_q == CW'(HALF - 1)) tap_d[0] = rx_i;
    if (cnt_q == CW'(HALF))     tap_d[1] = rx_i;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      tap_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      tap_q <= tap_d;
    end
  end

  // The vote is resolved one cycle after the centre tap, once the third tap is present.
  assign sample_o  = (cnt_q == CW'(HALF + 1));
  assign bit_end_o = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign bit_o     = maj3(tap_q[0], tap_q[1], rx_i);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority sampling, false-start rejection, parity/framing/break
// flags and a single-entry valid/ready output register with overrun pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = B115200,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  logic rx_meta_q, rx_s_q;
  logic sample, bit_end, bit_val;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop0_q, stop0_d;
  logic                 ferr_q, ferr_d;
  logic                 hold_q, hold_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] out_data_q;
  logic                 out_valid_q, perr_q, ferr_out_q, brk_q, ovr_q;
  logic                 par_sum, perr_new, brk_new;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .restart_i(state_q == S_IDLE),
    .rx_i     (rx_s_q),
    .sample_o (sample),
    .bit_end_o(bit_end),
    .bit_o    (bit_val)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_bit_d  = par_bit_q;
    stop0_d    = stop0_q;
    ferr_d     = ferr_q;
    hold_d     = hold_q & ~rx_s_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: if (!rx_s_q && !hold_q) state_d = S_START;
      S_START: begin
        if (sample && bit_val) state_d = S_IDLE;
        else if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d   = {bit_val, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
        end
        if (bit_end && bit_idx_q == 4'(DATA_BITS)) begin
          state_d    = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_PAR: begin
        if (sample) par_bit_d = bit_val;
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (!stop_idx_q) begin
            stop0_d = bit_val;
            ferr_d  = ~bit_val;
          end else begin
            ferr_d  = ferr_q | ~bit_val;
          end
          if (STOP_BITS == 1 || stop_idx_q) begin
            // Completing on a low stop bit means the line may still be low (break);
            // hold off start detection until it has been seen high again.
            state_d = S_IDLE;
            done_d  = 1'b1;
            hold_d  = ~bit_val;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_bit_q  <= 1'b0;
      stop0_q    <= 1'b0;
      ferr_q     <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_bit_q  <= par_bit_d;
      stop0_q    <= stop0_d;
      ferr_q     <= ferr_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    par_sum  = (^shreg_q) ^ par_bit_q;
    perr_new = 1'b0;
    if (PARITY == PAR_ODD)  perr_new = ~par_sum;
    if (PARITY == PAR_EVEN) perr_new = par_sum;
    brk_new  = (shreg_q == '0) && (PARITY == PAR_NONE || !par_bit_q) && !stop0_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      perr_q      <= 1'b0;
      ferr_out_q  <= 1'b0;
      brk_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!out_valid_q || out_ready) begin
          out_data_q  <= shreg_q;
          out_valid_q <= 1'b1;
          perr_q      <= perr_new;
          ferr_out_q  <= ferr_q;
          brk_q       <= brk_new;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_out_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed + randomized bench for uart_rx_cfg: three configurations (8N1@434, 8E1@32, 9N2@32)
// checked against a frame-level reference model.
module tb_uart_rx_cfg;

  typedef struct {
    int         inst;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
    int         cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rstn;
  logic rx_a, rx_b, rx_c;
  logic ready_a, ready_b, ready_c;
  logic [7:0] data_a, data_b;
  logic [8:0] data_c;
  logic valid_a, pe_a, fe_a, bk_a, ovr_a, busy_a;
  logic valid_b, pe_b, fe_b, bk_b, ovr_b, busy_b;
  logic valid_c, pe_c, fe_c, bk_c, ovr_c, busy_c;

  int   cyc = 0;
  int   passed = 0;
  int   failed = 0;
  int   total = 0;
  int   ovr_cnt [3] = '{0, 0, 0};
  obs_t obs_all[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg u_a (
    .clk(clk), .rstn(rstn), .rx(rx_a), .out_data(data_a), .out_valid(valid_a),
    .out_ready(ready_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a),
    .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(32), .PARITY(2)) u_b (
    .clk(clk), .rstn(rstn), .rx(rx_b), .out_data(data_b), .out_valid(valid_b),
    .out_ready(ready_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b),
    .overrun(ovr_b), .busy(busy_b)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(32), .DATA_BITS(9), .STOP_BITS(2)) u_c (
    .clk(clk), .rstn(rstn), .rx(rx_c), .out_data(data_c), .out_valid(valid_c),
    .out_ready(ready_c), .parity_err(pe_c), .frame_err(fe_c), .break_det(bk_c),
    .overrun(ovr_c), .busy(busy_c)
  );

  // Record every accepted word and every overrun cycle.
  always @(negedge clk) begin
    obs_t o;
    if (valid_a && ready_a) begin
      o.inst = 0; o.d = {1'b0, data_a}; o.pe = pe_a; o.fe = fe_a; o.bk = bk_a; o.cyc = cyc;
      obs_all.push_back(o);
    end
    if (valid_b && ready_b) begin
      o.inst = 1; o.d = {1'b0, data_b}; o.pe = pe_b; o.fe = fe_b; o.bk = bk_b; o.cyc = cyc;
      obs_all.push_back(o);
    end
    if (valid_c && ready_c) begin
      o.inst = 2; o.d = data_c; o.pe = pe_c; o.fe = fe_c; o.bk = bk_c; o.cyc = cyc;
      obs_all.push_back(o);
    end
    if (ovr_a) ovr_cnt[0]++;
    if (ovr_b) ovr_cnt[1]++;
    if (ovr_c) ovr_cnt[2]++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the receiver should report for a frame as sent on the wire.
  function automatic obs_t model(input int inst, input int nb, input logic [8:0] data,
                                 input int pmode, input logic pbit, input int nstop,
                                 input logic [1:0] stopv);
    obs_t m;
    int   ones;
    m.inst = inst;
    m.d    = '0;
    for (int i = 0; i < nb; i++) m.d[i] = data[i];
    ones   = $countones(m.d) + int'(pbit);
    m.pe   = (pmode == 1) ? (ones % 2 != 1) : (pmode == 2) ? (ones % 2 != 0) : 1'b0;
    m.fe   = !stopv[0] || (nstop == 2 && !stopv[1]);
    m.bk   = (m.d == 0) && (pmode == 0 || !pbit) && !stopv[0];
    m.cyc  = 0;
    return m;
  endfunction

  task automatic drive(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Sends up to nsend bits of a frame; glitch = frame bit index receiving a 1-cycle flip.
  task automatic send(input int inst, input int cpb, input int nb, input logic [8:0] data,
                      input int pmode, input logic pbit, input int nstop,
                      input logic [1:0] stopv, input int glitch, input int nsend);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(data[i]);
    if (pmode != 0) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stopv[i]);
    for (int i = 0; i < bits.size() && i < nsend; i++) begin
      for (int c = 0; c < cpb; c++) begin
        drive(inst, bits[i] ^ (i == glitch && c == cpb / 2 + 3));
        @(posedge clk); #1;
      end
    end
    drive(inst, 1'b1);
  endtask

  task automatic expect_word(input string tag, input obs_t e, output obs_t o);
    o = e;
    chk({tag, "_present"}, 32'(obs_all.size() > 0), 1);
    if (obs_all.size() > 0) begin
      o = obs_all.pop_front();
      chk({tag, "_inst"}, o.inst, e.inst);
      chk({tag, "_data"}, 32'(o.d), 32'(e.d));
      chk({tag, "_perr"}, 32'(o.pe), 32'(e.pe));
      chk({tag, "_ferr"}, 32'(o.fe), 32'(e.fe));
      chk({tag, "_brk"},  32'(o.bk), 32'(e.bk));
    end
  endtask

  initial begin
    obs_t       o;
    int         start, lat, base;
    logic [8:0] d;
    logic       p;
    logic [1:0] sv;

    rstn = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_valid", {valid_a, valid_b, valid_c}, 0);
    chk("rst_busy", {busy_a, busy_b, busy_c}, 0);
    chk("rst_data", {data_a, data_b, data_c}, 0);
    chk("rst_flags", {pe_a, fe_a, bk_a, ovr_a, pe_b, fe_b, bk_b, ovr_b, pe_c, fe_c, bk_c, ovr_c}, 0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 8N1 at 434 clocks/bit, word 0xA5 with latency check
    start = cyc;
    send(0, 434, 8, 9'h0A5, 0, 1'b0, 1, 2'b11, -1, 99);
    repeat (10) @(posedge clk);
    #1;
    expect_word("t1", model(0, 8, 9'h0A5, 0, 1'b0, 1, 2'b11), o);
    lat = o.cyc - start;
    chk("t1_latency", 32'(lat >= 4126 && lat <= 4130), 1);
    chk("t1_single", obs_all.size(), 0);
    chk("t1_valid_low", valid_a, 0);

    // Even parity: 0x03 with wrong then right parity bit
    send(1, 32, 8, 9'h003, 2, 1'b1, 1, 2'b11, -1, 99);
    repeat (64) @(posedge clk);
    #1;
    expect_word("t2_bad", model(1, 8, 9'h003, 2, 1'b1, 1, 2'b11), o);
    send(1, 32, 8, 9'h003, 2, 1'b0, 1, 2'b11, -1, 99);
    repeat (64) @(posedge clk);
    #1;
    expect_word("t2_good", model(1, 8, 9'h003, 2, 1'b0, 1, 2'b11), o);
    for (int k = 0; k < 6; k++) begin
      d  = 9'($urandom_range(0, 255));
      p  = 1'($urandom_range(0, 1));
      sv = {1'b1, 1'($urandom_range(0, 3) != 0)};
      send(1, 32, 8, d, 2, p, 1, sv, -1, 99);
      repeat (64) @(posedge clk);
      #1;
      expect_word("t2_rand", model(1, 8, d, 2, p, 1, sv), o);
    end

    // False start: 100-cycle low pulse on the 434 receiver
    for (int c = 0; c < 100; c++) begin
      rx_a = 1'b0;
      @(posedge clk); #1;
    end
    chk("t3_busy_in_start", busy_a, 1);
    rx_a = 1'b1;
    repeat (434) @(posedge clk);
    #1;
    chk("t3_idle", busy_a, 0);
    chk("t3_no_word", obs_all.size(), 0);
    chk("t3_valid", valid_a, 0);

    // Overrun: consumer stalled over two frames
    base = ovr_cnt[1];
    ready_b = 1'b0;
    send(1, 32, 8, 9'h011, 2, 1'b0, 1, 2'b11, -1, 99);
    repeat (64) @(posedge clk);
    #1;
    send(1, 32, 8, 9'h022, 2, 1'b0, 1, 2'b11, -1, 99);
    repeat (64) @(posedge clk);
    #1;
    chk("t4_ovr_pulses", ovr_cnt[1] - base, 1);
    chk("t4_held_valid", valid_b, 1);
    chk("t4_held_data", data_b, 8'h11);
    chk("t4_none_accepted", obs_all.size(), 0);
    ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_word("t4_acc", model(1, 8, 9'h011, 2, 1'b0, 1, 2'b11), o);
    chk("t4_no_second", obs_all.size(), 0);
    chk("t4_valid_low", valid_b, 0);

    // Break: line low for 12 bit times
    for (int c = 0; c < 384; c++) begin
      rx_b = 1'b0;
      if (c == 368) chk("t5_waits_idle", busy_b, 0);
      @(posedge clk); #1;
    end
    rx_b = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    expect_word("t5_brk", model(1, 8, 9'h000, 2, 1'b0, 1, 2'b00), o);
    chk("t5_one_word", obs_all.size(), 0);
    chk("t5_idle", busy_b, 0);
    send(1, 32, 8, 9'h05A, 2, 1'b0, 1, 2'b11, -1, 99);
    repeat (64) @(posedge clk);
    #1;
    expect_word("t5_recover", model(1, 8, 9'h05A, 2, 1'b0, 1, 2'b11), o);

    // 9 data bits, 2 stop bits, random frames with a single-cycle glitch
    for (int k = 0; k < 4; k++) begin
      d  = 9'($urandom_range(0, 511));
      sv = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      send(2, 32, 9, d, 0, 1'b0, 2, sv, int'($urandom_range(0, 12)), 99);
      repeat (64) @(posedge clk);
      #1;
      expect_word("t6_rand", model(2, 9, d, 0, 1'b0, 2, sv), o);
    end
    send(2, 32, 9, 9'h1FF, 0, 1'b0, 2, 2'b11, 3, 99);
    send(2, 32, 9, 9'h0AA, 0, 1'b0, 2, 2'b11, 1, 99);
    send(2, 32, 9, 9'h155, 0, 1'b0, 2, 2'b11, -1, 5);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    expect_word("t6_b2b0", model(2, 9, 9'h1FF, 0, 1'b0, 2, 2'b11), o);
    expect_word("t6_b2b1", model(2, 9, 9'h0AA, 0, 1'b0, 2, 2'b11), o);
    chk("t6_rst_busy", busy_c, 0);
    repeat (400) @(posedge clk);
    #1;
    chk("t6_rst_no_word", obs_all.size(), 0);
    chk("t6_rst_valid", valid_c, 0);
    chk("t6_rst_idle", busy_c, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
